// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller: dual-lane allocation, completion
// tracking and in-order dual retire, plus the address/enable drive for the ROB RAM.
module rob_ctrl #(
   parameter int ADDR  = 4,
   parameter int DEPTH = 1 << ADDR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            alloc_req_0,
   input  logic            alloc_req_1,
   output logic            alloc_gnt_0,
   output logic            alloc_gnt_1,
   output logic [ADDR-1:0] alloc_tag_0,
   output logic [ADDR-1:0] alloc_tag_1,
   input  logic            cpl_valid_0,
   input  logic            cpl_valid_1,
   input  logic [ADDR-1:0] cpl_tag_0,
   input  logic [ADDR-1:0] cpl_tag_1,
   input  logic            commit_ready,
   output logic            commit_valid_0,
   output logic            commit_valid_1,
   output logic [ADDR-1:0] commit_tag_0,
   output logic [ADDR-1:0] commit_tag_1,
   input  logic            lkp_en,
   input  logic [ADDR-1:0] lkp_tag,
   output logic            lkp_hit,
   output logic            ram_wr_en_0,
   output logic            ram_wr_en_1,
   output logic [ADDR-1:0] ram_addr_in_0,
   output logic [ADDR-1:0] ram_addr_in_1,
   output logic            ram_o_en_0,
   output logic            ram_o_en_1,
   output logic [ADDR-1:0] ram_addr_out_0,
   output logic [ADDR-1:0] ram_addr_out_1,
   output logic            ram_o_en_2,
   output logic [ADDR-1:0] ram_addr_out_2,
   output logic [ADDR:0]   count,
   output logic            empty,
   output logic            full
);

   localparam logic [ADDR:0] LP_DEPTH = (ADDR+1)'(DEPTH);

   logic [ADDR-1:0]  r_head;
   logic [ADDR-1:0]  r_tail;
   logic [ADDR:0]    r_count;
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_done;

   logic [ADDR:0]    w_free;
   logic [ADDR-1:0]  w_tail1;
   logic [ADDR-1:0]  w_head1;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_cv0;
   logic             w_cv1;
   logic             w_fire0;
   logic             w_fire1;
   logic [DEPTH-1:0] w_validNext;
   logic [DEPTH-1:0] w_doneNext;
   logic [ADDR:0]    w_countNext;

   // Free space comes from the registered count, so slots retired this
   // cycle only become allocatable on the following cycle.
   assign w_free  = LP_DEPTH - r_count;
   assign w_tail1 = r_tail + ADDR'(1);
   assign w_head1 = r_head + ADDR'(1);

   assign w_gnt0  = alloc_req_0 && (w_free >= (ADDR+1)'(1)) && !flush;
   assign w_gnt1  = alloc_req_0 && alloc_req_1 && (w_free >= (ADDR+1)'(2)) && !flush;

   assign w_cv0   = r_valid[r_head] && r_done[r_head] && !flush;
   assign w_cv1   = w_cv0 && (r_count >= (ADDR+1)'(2)) && r_valid[w_head1] && r_done[w_head1];
   assign w_fire0 = w_cv0 && commit_ready;
   assign w_fire1 = w_cv1 && commit_ready;

   assign w_countNext = r_count + (ADDR+1)'(w_gnt0) + (ADDR+1)'(w_gnt1)
                        - (ADDR+1)'(w_fire0) - (ADDR+1)'(w_fire1);

   // Completions are applied before retire clears, then allocation; the sets
   // never collide because allocated slots are free and retiring slots are done.
   always_comb begin
      w_validNext = r_valid;
      w_doneNext  = r_done;
      if (cpl_valid_0 && r_valid[cpl_tag_0]) w_doneNext[cpl_tag_0] = 1'b1;
      if (cpl_valid_1 && r_valid[cpl_tag_1]) w_doneNext[cpl_tag_1] = 1'b1;
      if (w_fire0) begin
         w_validNext[r_head] = 1'b0;
         w_doneNext[r_head]  = 1'b0;
      end
      if (w_fire1) begin
         w_validNext[w_head1] = 1'b0;
         w_doneNext[w_head1]  = 1'b0;
      end
      if (w_gnt0) begin
         w_validNext[r_tail] = 1'b1;
         w_doneNext[r_tail]  = 1'b0;
      end
      if (w_gnt1) begin
         w_validNext[w_tail1] = 1'b1;
         w_doneNext[w_tail1]  = 1'b0;
      end
      if (flush) begin
         w_validNext = '0;
         w_doneNext  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_done  <= '0;
      end else begin
         r_valid <= w_validNext;
         r_done  <= w_doneNext;
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            r_head  <= r_head + ADDR'(w_fire0) + ADDR'(w_fire1);
            r_tail  <= r_tail + ADDR'(w_gnt0) + ADDR'(w_gnt1);
            r_count <= w_countNext;
         end
      end
   end

   assign alloc_gnt_0    = w_gnt0;
   assign alloc_gnt_1    = w_gnt1;
   assign alloc_tag_0    = r_tail;
   assign alloc_tag_1    = w_tail1;
   assign commit_valid_0 = w_cv0;
   assign commit_valid_1 = w_cv1;
   assign commit_tag_0   = r_head;
   assign commit_tag_1   = w_head1;
   assign lkp_hit        = lkp_en && r_valid[lkp_tag] && r_done[lkp_tag];

   assign ram_wr_en_0    = w_gnt0;
   assign ram_wr_en_1    = w_gnt1;
   assign ram_addr_in_0  = r_tail;
   assign ram_addr_in_1  = w_tail1;
   assign ram_o_en_0     = w_cv0;
   assign ram_o_en_1     = w_cv1;
   assign ram_addr_out_0 = r_head;
   assign ram_addr_out_1 = w_head1;
   assign ram_o_en_2     = lkp_en;
   assign ram_addr_out_2 = lkp_tag;

   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == LP_DEPTH);

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl (ADDR=4, DEPTH=16): each task
// drives one scenario and checks hand-computed values inline.
module tb_rob_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       alloc_req_0, alloc_req_1;
   logic       alloc_gnt_0, alloc_gnt_1;
   logic [3:0] alloc_tag_0, alloc_tag_1;
   logic       cpl_valid_0, cpl_valid_1;
   logic [3:0] cpl_tag_0, cpl_tag_1;
   logic       commit_ready;
   logic       commit_valid_0, commit_valid_1;
   logic [3:0] commit_tag_0, commit_tag_1;
   logic       lkp_en;
   logic [3:0] lkp_tag;
   logic       lkp_hit;
   logic       ram_wr_en_0, ram_wr_en_1;
   logic [3:0] ram_addr_in_0, ram_addr_in_1;
   logic       ram_o_en_0, ram_o_en_1;
   logic [3:0] ram_addr_out_0, ram_addr_out_1;
   logic       ram_o_en_2;
   logic [3:0] ram_addr_out_2;
   logic [4:0] count;
   logic       empty, full;

   int nTests = 0;
   int nFail  = 0;

   rob_ctrl #(.ADDR(4), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
      .alloc_gnt_0(alloc_gnt_0), .alloc_gnt_1(alloc_gnt_1),
      .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
      .cpl_valid_0(cpl_valid_0), .cpl_valid_1(cpl_valid_1),
      .cpl_tag_0(cpl_tag_0), .cpl_tag_1(cpl_tag_1),
      .commit_ready(commit_ready),
      .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
      .commit_tag_0(commit_tag_0), .commit_tag_1(commit_tag_1),
      .lkp_en(lkp_en), .lkp_tag(lkp_tag), .lkp_hit(lkp_hit),
      .ram_wr_en_0(ram_wr_en_0), .ram_wr_en_1(ram_wr_en_1),
      .ram_addr_in_0(ram_addr_in_0), .ram_addr_in_1(ram_addr_in_1),
      .ram_o_en_0(ram_o_en_0), .ram_o_en_1(ram_o_en_1),
      .ram_addr_out_0(ram_addr_out_0), .ram_addr_out_1(ram_addr_out_1),
      .ram_o_en_2(ram_o_en_2), .ram_addr_out_2(ram_addr_out_2),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      flush = 0; alloc_req_0 = 0; alloc_req_1 = 0;
      cpl_valid_0 = 0; cpl_valid_1 = 0; cpl_tag_0 = 0; cpl_tag_1 = 0;
      commit_ready = 0; lkp_en = 0; lkp_tag = 0;
   endtask

   task automatic test_reset();
      clearInputs();
      reset = 0;
      #12;
      nTests++; if (count !== 5'd0) begin nFail++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
      nTests++; if (empty !== 1'b1 || full !== 1'b0) begin nFail++; $display("[TB] FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
      nTests++; if (commit_valid_0 !== 1'b0 || commit_valid_1 !== 1'b0 || ram_o_en_0 !== 1'b0 || ram_o_en_1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_commit cv=%b%b oen=%b%b exp 0000", commit_valid_0, commit_valid_1, ram_o_en_0, ram_o_en_1); end
      alloc_req_0 = 1; alloc_req_1 = 1;
      #1;
      nTests++; if (alloc_gnt_0 !== 1'b1 || alloc_gnt_1 !== 1'b1 || alloc_tag_0 !== 4'd0 || alloc_tag_1 !== 4'd1) begin nFail++; $display("[TB] FAIL reset_grant gnt=%b%b tags=%0d/%0d exp 11 0/1", alloc_gnt_0, alloc_gnt_1, alloc_tag_0, alloc_tag_1); end
      alloc_req_0 = 0; alloc_req_1 = 0;
      tick();
      reset = 1;
      tick();
   endtask

   task automatic test_fill();
      alloc_req_0 = 1; alloc_req_1 = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         nTests++;
         if (alloc_gnt_0 !== 1'b1 || alloc_gnt_1 !== 1'b1 || alloc_tag_0 !== 4'(2*i) || alloc_tag_1 !== 4'(2*i+1)
             || ram_wr_en_0 !== 1'b1 || ram_wr_en_1 !== 1'b1 || ram_addr_in_0 !== 4'(2*i) || ram_addr_in_1 !== 4'(2*i+1)) begin
            nFail++;
            $display("[TB] FAIL fill_%0d gnt=%b%b tags=%0d/%0d exp 11 %0d/%0d", i, alloc_gnt_0, alloc_gnt_1, alloc_tag_0, alloc_tag_1, 2*i, 2*i+1);
         end
         tick();
      end
      #1;
      nTests++; if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin nFail++; $display("[TB] FAIL fill_full count=%0d full=%b exp 16 1", count, full); end
      nTests++; if (alloc_gnt_0 !== 1'b0 || alloc_gnt_1 !== 1'b0) begin nFail++; $display("[TB] FAIL fill_blocked gnt=%b%b exp 00", alloc_gnt_0, alloc_gnt_1); end
      alloc_req_0 = 0; alloc_req_1 = 0;
   endtask

   task automatic test_full_commit();
      cpl_valid_0 = 1; cpl_tag_0 = 4'd0; cpl_valid_1 = 1; cpl_tag_1 = 4'd1;
      tick();
      cpl_valid_0 = 0; cpl_valid_1 = 0;
      #1;
      nTests++; if (commit_valid_0 !== 1'b1 || commit_valid_1 !== 1'b1 || commit_tag_0 !== 4'd0 || commit_tag_1 !== 4'd1) begin nFail++; $display("[TB] FAIL fullc_cv cv=%b%b tags=%0d/%0d exp 11 0/1", commit_valid_0, commit_valid_1, commit_tag_0, commit_tag_1); end
      commit_ready = 1; alloc_req_0 = 1; alloc_req_1 = 1;
      #1;
      nTests++; if (alloc_gnt_0 !== 1'b0 || alloc_gnt_1 !== 1'b0) begin nFail++; $display("[TB] FAIL fullc_samecycle gnt=%b%b exp 00", alloc_gnt_0, alloc_gnt_1); end
      tick();
      commit_ready = 0;
      #1;
      nTests++; if (count !== 5'd14) begin nFail++; $display("[TB] FAIL fullc_count got %0d exp 14", count); end
      nTests++; if (alloc_gnt_0 !== 1'b1 || alloc_gnt_1 !== 1'b1 || alloc_tag_0 !== 4'd0 || alloc_tag_1 !== 4'd1) begin nFail++; $display("[TB] FAIL fullc_wrapgnt gnt=%b%b tags=%0d/%0d exp 11 0/1", alloc_gnt_0, alloc_gnt_1, alloc_tag_0, alloc_tag_1); end
      tick();
      alloc_req_0 = 0; alloc_req_1 = 0;
      #1;
      nTests++; if (count !== 5'd16 || full !== 1'b1 || commit_tag_0 !== 4'd2) begin nFail++; $display("[TB] FAIL fullc_refill count=%0d full=%b head=%0d exp 16 1 2", count, full, commit_tag_0); end
   endtask

   task automatic test_partial();
      cpl_valid_0 = 1; cpl_tag_0 = 4'd2;
      tick();
      cpl_valid_0 = 0;
      #1;
      nTests++; if (commit_valid_0 !== 1'b1 || commit_valid_1 !== 1'b0) begin nFail++; $display("[TB] FAIL part_cv cv=%b%b exp 10", commit_valid_0, commit_valid_1); end
      commit_ready = 1;
      tick();
      commit_ready = 0;
      alloc_req_0 = 1; alloc_req_1 = 1;
      #1;
      nTests++; if (count !== 5'd15) begin nFail++; $display("[TB] FAIL part_count got %0d exp 15", count); end
      nTests++; if (alloc_gnt_0 !== 1'b1 || alloc_gnt_1 !== 1'b0 || alloc_tag_0 !== 4'd2) begin nFail++; $display("[TB] FAIL part_gnt gnt=%b%b tag0=%0d exp 10 2", alloc_gnt_0, alloc_gnt_1, alloc_tag_0); end
      tick();
      alloc_req_0 = 0; alloc_req_1 = 0;
      #1;
      nTests++; if (count !== 5'd16 || full !== 1'b1) begin nFail++; $display("[TB] FAIL part_full count=%0d full=%b exp 16 1", count, full); end
   endtask

   task automatic test_flush();
      int hits;
      cpl_valid_0 = 1; cpl_tag_0 = 4'd3;
      tick();
      cpl_valid_0 = 0;
      #1;
      nTests++; if (commit_valid_0 !== 1'b1 || commit_tag_0 !== 4'd3) begin nFail++; $display("[TB] FAIL flush_pre cv0=%b head=%0d exp 1 3", commit_valid_0, commit_tag_0); end
      flush = 1; cpl_valid_0 = 1; cpl_tag_0 = 4'd4; alloc_req_0 = 1; alloc_req_1 = 1; commit_ready = 1;
      #1;
      nTests++; if (alloc_gnt_0 !== 1'b0 || alloc_gnt_1 !== 1'b0 || commit_valid_0 !== 1'b0 || commit_valid_1 !== 1'b0) begin nFail++; $display("[TB] FAIL flush_cycle gnt=%b%b cv=%b%b exp 0000", alloc_gnt_0, alloc_gnt_1, commit_valid_0, commit_valid_1); end
      tick();
      clearInputs();
      #1;
      nTests++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin nFail++; $display("[TB] FAIL flush_count count=%0d empty=%b exp 0 1", count, empty); end
      nTests++; if (alloc_tag_0 !== 4'd0 || commit_tag_0 !== 4'd0) begin nFail++; $display("[TB] FAIL flush_ptrs tail=%0d head=%0d exp 0 0", alloc_tag_0, commit_tag_0); end
      hits = 0;
      lkp_en = 1;
      for (int t = 0; t < 16; t++) begin
         lkp_tag = 4'(t);
         #1;
         if (lkp_hit !== 1'b0) hits++;
      end
      lkp_en = 0;
      nTests++; if (hits != 0) begin nFail++; $display("[TB] FAIL flush_lkp hits=%0d exp 0", hits); end
   endtask

   task automatic test_commit_order();
      alloc_req_0 = 1; alloc_req_1 = 1;
      tick();
      tick();
      alloc_req_0 = 0; alloc_req_1 = 0;
      cpl_valid_0 = 1; cpl_tag_0 = 4'd1;
      tick();
      cpl_tag_0 = 4'd0;
      #1;
      nTests++; if (count !== 5'd4 || commit_valid_0 !== 1'b0) begin nFail++; $display("[TB] FAIL order_wait count=%0d cv0=%b exp 4 0", count, commit_valid_0); end
      tick();
      cpl_valid_0 = 0;
      #1;
      nTests++; if (commit_valid_0 !== 1'b1 || commit_valid_1 !== 1'b1 || commit_tag_0 !== 4'd0 || commit_tag_1 !== 4'd1 || ram_o_en_1 !== 1'b1 || ram_addr_out_1 !== 4'd1) begin nFail++; $display("[TB] FAIL order_pair cv=%b%b tags=%0d/%0d exp 11 0/1", commit_valid_0, commit_valid_1, commit_tag_0, commit_tag_1); end
      commit_ready = 1;
      tick();
      commit_ready = 0;
      lkp_en = 1; lkp_tag = 4'd2;
      #1;
      nTests++; if (count !== 5'd2 || commit_tag_0 !== 4'd2 || commit_valid_0 !== 1'b0 || lkp_hit !== 1'b0) begin nFail++; $display("[TB] FAIL order_tag2 count=%0d head=%0d cv0=%b hit=%b exp 2 2 0 0", count, commit_tag_0, commit_valid_0, lkp_hit); end
      cpl_valid_1 = 1; cpl_tag_1 = 4'd2;
      tick();
      cpl_valid_1 = 0;
      #1;
      nTests++; if (commit_valid_0 !== 1'b1 || commit_valid_1 !== 1'b0) begin nFail++; $display("[TB] FAIL order_cpl2 cv=%b%b exp 10", commit_valid_0, commit_valid_1); end
      nTests++; if (lkp_hit !== 1'b1 || ram_o_en_2 !== 1'b1 || ram_addr_out_2 !== 4'd2) begin nFail++; $display("[TB] FAIL order_lkp hit=%b oen2=%b addr2=%0d exp 1 1 2", lkp_hit, ram_o_en_2, ram_addr_out_2); end
      lkp_en = 0;
   endtask

   task automatic test_hold();
      int bad;
      bad = 0;
      commit_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (count !== 5'd2 || commit_tag_0 !== 4'd2 || commit_valid_0 !== 1'b1) bad++;
      end
      nTests++; if (bad != 0) begin nFail++; $display("[TB] FAIL hold_stable badcycles=%0d exp 0 (count=%0d head=%0d)", bad, count, commit_tag_0); end
      commit_ready = 1;
      tick();
      commit_ready = 0;
      #1;
      nTests++; if (count !== 5'd1 || commit_tag_0 !== 4'd3 || commit_valid_0 !== 1'b0) begin nFail++; $display("[TB] FAIL hold_release count=%0d head=%0d cv0=%b exp 1 3 0", count, commit_tag_0, commit_valid_0); end
   endtask

   task automatic test_invalid_cpl();
      cpl_valid_0 = 1; cpl_tag_0 = 4'd9; cpl_valid_1 = 1; cpl_tag_1 = 4'd3;
      tick();
      cpl_valid_0 = 0; cpl_valid_1 = 0;
      lkp_en = 1; lkp_tag = 4'd9;
      #1;
      nTests++; if (lkp_hit !== 1'b0) begin nFail++; $display("[TB] FAIL inv_tag9 hit=%b exp 0", lkp_hit); end
      lkp_tag = 4'd3;
      #1;
      nTests++; if (lkp_hit !== 1'b1 || commit_valid_0 !== 1'b1 || count !== 5'd1) begin nFail++; $display("[TB] FAIL inv_tag3 hit=%b cv0=%b count=%0d exp 1 1 1", lkp_hit, commit_valid_0, count); end
      lkp_en = 0;
      #1;
      nTests++; if (lkp_hit !== 1'b0) begin nFail++; $display("[TB] FAIL inv_lkpen hit=%b exp 0", lkp_hit); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_commit();
      test_partial();
      test_flush();
      test_commit_order();
      test_hold();
      test_invalid_cpl();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
